keypad_scan_module: RTL

KEYPAD_SCAN_MODULE -- requirements
Module: keypad_scan_module

---
 rtl/keypad_scan_module.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/keypad_scan_module.sv
// 4x4 matrix keypad scanner: drives rows one-cold, samples synchronized
// columns once per row slot, debounces whole-keypad frames and reports
// each new single-key press once, shifting its code into a 6-digit buffer.
//
// Key_Valid is a one-cycle event pulse with no back-pressure: Key_Code and
// Number_Sig are already updated in the pulse cycle and stay valid until
// the next pulse.
module keypad_scan_module #(
    parameter int SCAN_TICKS      = 50000,
    parameter int DEBOUNCE_FRAMES = 10
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [3:0]  Col_Sig,
    output logic [3:0]  Row_Sig,
    output logic        Key_Valid,
    output logic [3:0]  Key_Code,
    output logic        Key_Down,
    output logic [23:0] Number_Sig
);

    localparam int            TW         = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(SCAN_TICKS - 1);
    localparam logic [7:0]    STABLE_MAX = 8'(DEBOUNCE_FRAMES);

    logic [3:0]    col_meta_q, col_sync_q;
    logic [TW-1:0] tick_q, tick_d;
    logic [1:0]    row_q, row_d;
    logic [11:0]   acc_q, acc_d;       // rows 0..2 of the frame being built
    logic [15:0]   prev_q, prev_d;     // previous raw frame
    logic [15:0]   deb_q, deb_d;       // debounced keypad state
    logic [15:0]   deb_old_q, deb_old_d;
    logic [7:0]    stable_q, stable_d;
    logic          upd_q, upd_d;       // debounced state was loaded last edge
    logic          valid_q, valid_d;
    logic [3:0]    code_q, code_d;
    logic          down_q;
    logic [23:0]   num_q, num_d;

    logic        slot_end, frame_end, load_deb, single;
    logic [3:0]  pressed;
    logic [15:0] frame_new;
    logic [3:0]  key_idx;

    function automatic logic [3:0] bit_index(input logic [15:0] v);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) r = 4'(i);
        end
        return r;
    endfunction

    // Two-flop synchronizer on the asynchronous column lines.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            col_meta_q <= 4'b1111;
            col_sync_q <= 4'b1111;
        end else begin
            col_meta_q <= Col_Sig;
            col_sync_q <= col_meta_q;
        end
    end

    // Scan timing, frame assembly and debounce next-state logic.
    always_comb begin
        slot_end  = (tick_q == TICK_LAST);
        frame_end = slot_end && (row_q == 2'd3);
        pressed   = ~col_sync_q;
        frame_new = {pressed, acc_q};

        tick_d    = slot_end ? '0 : tick_q + 1'b1;
        row_d     = slot_end ? row_q + 2'd1 : row_q;

        acc_d = acc_q;
        if (slot_end) begin
            case (row_q)
                2'd0:    acc_d[3:0]  = pressed;
                2'd1:    acc_d[7:4]  = pressed;
                2'd2:    acc_d[11:8] = pressed;
                default: acc_d       = acc_q;
            endcase
        end

        stable_d = stable_q;
        prev_d   = prev_q;
        if (frame_end) begin
            prev_d = frame_new;
            if (frame_new != prev_q)        stable_d = 8'd0;
            else if (stable_q < STABLE_MAX) stable_d = stable_q + 8'd1;
        end

        load_deb  = frame_end && (stable_d == STABLE_MAX);
        deb_d     = load_deb ? frame_new : deb_q;
        deb_old_d = load_deb ? deb_q : deb_old_q;
        upd_d     = load_deb;
    end

    // Scanner and debounce state registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tick_q    <= '0;
            row_q     <= 2'd0;
            acc_q     <= '0;
            prev_q    <= '0;
            deb_q     <= '0;
            deb_old_q <= '0;
            stable_q  <= '0;
            upd_q     <= 1'b0;
        end else begin
            tick_q    <= tick_d;
            row_q     <= row_d;
            acc_q     <= acc_d;
            prev_q    <= prev_d;
            deb_q     <= deb_d;
            deb_old_q <= deb_old_d;
            stable_q  <= stable_d;
            upd_q     <= upd_d;
        end
    end

    // A press is a debounced change from all-released to exactly one key.
    always_comb begin
        single  = (deb_q != 16'd0) && ((deb_q & (deb_q - 16'd1)) == 16'd0);
        key_idx = bit_index(deb_q);
        valid_d = upd_q && single && (deb_old_q == 16'd0);
        code_d  = valid_d ? key_idx : code_q;
        num_d   = valid_d ? {num_q[19:0], key_idx} : num_q;
    end

    // Output registers: press pulse, held code, entry buffer, key-down level.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            valid_q <= 1'b0;
            code_q  <= 4'd0;
            num_q   <= '0;
            down_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            code_q  <= code_d;
            num_q   <= num_d;
            down_q  <= |deb_q;
        end
    end

    assign Row_Sig    = ~(4'b0001 << row_q);
    assign Key_Valid  = valid_q;
    assign Key_Code   = code_q;
    assign Key_Down   = down_q;
    assign Number_Sig = num_q;

endmodule
